// File: rtl/tl45_operand_fetch.sv
// tl45 operand-fetch stage: DPRF read addressing, prioritised forwarding, immediate select, output buffer.
// Define TL45_LOADUSE_INTERLOCK_EN to enable the load-use interlock, bubble injection and hazard counter.
module tl45_operand_fetch #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned RAW         = 4,
   parameter int unsigned NFWD        = 2,
   parameter logic [15:0] IMM_OP_MASK = 16'h0004
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_pipe_stall,
   input  logic                 i_pipe_flush,
   output logic                 o_pipe_stall,
   output logic                 o_pipe_flush,
   input  logic                 i_valid,
   input  logic [31:0]          i_pc,
   input  logic [3:0]           i_opcode,
   input  logic                 i_skp_mode,
   input  logic [RAW-1:0]       i_dr,
   input  logic [RAW-1:0]       i_sr1,
   input  logic [RAW-1:0]       i_sr2,
   input  logic [XLEN-1:0]      i_imm32,
   output logic [RAW-1:0]       o_dprf_read_a1,
   output logic [RAW-1:0]       o_dprf_read_a2,
   input  logic [XLEN-1:0]      i_dprf_d1,
   input  logic [XLEN-1:0]      i_dprf_d2,
   input  logic [NFWD*RAW-1:0]  i_fwd_reg,
   input  logic [NFWD*XLEN-1:0] i_fwd_data,
   input  logic [NFWD-1:0]      i_fwd_pending,
   output logic                 o_valid,
   output logic [31:0]          o_pc,
   output logic [3:0]           o_opcode,
   output logic [RAW-1:0]       o_dr,
   output logic                 o_skp_mode,
   output logic [XLEN-1:0]      o_sr1_val,
   output logic [XLEN-1:0]      o_sr2_val,
   output logic [XLEN-1:0]      o_target_address,
   output logic                 o_hazard,
   output logic [15:0]          o_hazard_cycles
);

   logic [XLEN-1:0] sr1_val, sr2_fwd_val, sr2_val;
   logic            sr1_pend, sr2_pend, sr2_imm, hazard;

   assign o_dprf_read_a1 = i_sr1;
   assign o_dprf_read_a2 = i_sr2;
   assign o_pipe_flush   = i_pipe_flush;

   always_comb begin
      sr1_val     = i_dprf_d1;
      sr1_pend    = 1'b0;
      sr2_fwd_val = i_dprf_d2;
      sr2_pend    = 1'b0;
      // Walk from lowest priority upward so the youngest matching bus is written last.
      for (int unsigned k = 0; k < NFWD; k++) begin
         if (i_fwd_reg[(NFWD-1-k)*RAW +: RAW] == i_sr1) begin
            sr1_val  = i_fwd_data[(NFWD-1-k)*XLEN +: XLEN];
            sr1_pend = i_fwd_pending[NFWD-1-k];
         end
         if (i_fwd_reg[(NFWD-1-k)*RAW +: RAW] == i_sr2) begin
            sr2_fwd_val = i_fwd_data[(NFWD-1-k)*XLEN +: XLEN];
            sr2_pend    = i_fwd_pending[NFWD-1-k];
         end
      end
      if (i_sr1 == '0) begin
         sr1_val  = '0;
         sr1_pend = 1'b0;
      end
      if (i_sr2 == '0) begin
         sr2_fwd_val = '0;
         sr2_pend    = 1'b0;
      end
      sr2_imm = IMM_OP_MASK[i_opcode];
      sr2_val = sr2_imm ? i_imm32 : sr2_fwd_val;
   end

`ifdef TL45_LOADUSE_INTERLOCK_EN
   assign hazard       = i_valid && (sr1_pend || (!sr2_imm && sr2_pend));
   assign o_pipe_stall = i_pipe_stall || hazard;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_hazard_cycles <= '0;
      end else if (hazard && (o_hazard_cycles != '1)) begin
         o_hazard_cycles <= o_hazard_cycles + 16'd1;
      end
   end
`else
   logic unused_pend;
   assign unused_pend     = sr1_pend ^ sr2_pend;
   assign hazard          = 1'b0;
   assign o_pipe_stall    = i_pipe_stall;
   assign o_hazard_cycles = '0;
`endif

   assign o_hazard = hazard;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_pipe_flush || (!i_pipe_stall && hazard)) begin
         // Clear and bubble share the same encoding: invalid, opcode F, zeroed fields.
         o_valid          <= 1'b0;
         o_pc             <= '0;
         o_opcode         <= 4'hF;
         o_dr             <= '0;
         o_skp_mode       <= 1'b0;
         o_sr1_val        <= '0;
         o_sr2_val        <= '0;
         o_target_address <= '0;
      end else if (!i_pipe_stall) begin
         o_valid          <= i_valid;
         o_pc             <= i_pc;
         o_opcode         <= i_opcode;
         o_dr             <= i_dr;
         o_skp_mode       <= i_skp_mode;
         o_sr1_val        <= sr1_val;
         o_sr2_val        <= sr2_val;
         o_target_address <= i_imm32;
      end
   end

endmodule

// File: tb/tb_tl45_operand_fetch.sv
// Scoreboard bench for tl45_operand_fetch: directed cases plus randomized traffic against a reference model.
module tb_tl45_operand_fetch;

   localparam int unsigned XLEN = 32;
   localparam int unsigned RAW  = 4;
   localparam int unsigned NFWD = 2;
   localparam logic [15:0] MASK = 16'h0004;
`ifdef TL45_LOADUSE_INTERLOCK_EN
   localparam bit ILK = 1'b1;
`else
   localparam bit ILK = 1'b0;
`endif

   logic                 i_clk = 1'b0;
   logic                 i_reset, i_pipe_stall, i_pipe_flush, i_valid, i_skp_mode;
   logic [31:0]          i_pc;
   logic [3:0]           i_opcode;
   logic [RAW-1:0]       i_dr, i_sr1, i_sr2;
   logic [XLEN-1:0]      i_imm32, i_dprf_d1, i_dprf_d2;
   logic [NFWD*RAW-1:0]  i_fwd_reg;
   logic [NFWD*XLEN-1:0] i_fwd_data;
   logic [NFWD-1:0]      i_fwd_pending;
   logic                 o_pipe_stall, o_pipe_flush, o_valid, o_skp_mode, o_hazard;
   logic [31:0]          o_pc;
   logic [3:0]           o_opcode;
   logic [RAW-1:0]       o_dr, o_dprf_read_a1, o_dprf_read_a2;
   logic [XLEN-1:0]      o_sr1_val, o_sr2_val, o_target_address;
   logic [15:0]          o_hazard_cycles;

   always #5 i_clk = ~i_clk;

   tl45_operand_fetch #(.XLEN(XLEN), .RAW(RAW), .NFWD(NFWD), .IMM_OP_MASK(MASK)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_pipe_stall(i_pipe_stall), .i_pipe_flush(i_pipe_flush),
      .o_pipe_stall(o_pipe_stall), .o_pipe_flush(o_pipe_flush), .i_valid(i_valid), .i_pc(i_pc),
      .i_opcode(i_opcode), .i_skp_mode(i_skp_mode), .i_dr(i_dr), .i_sr1(i_sr1), .i_sr2(i_sr2),
      .i_imm32(i_imm32), .o_dprf_read_a1(o_dprf_read_a1), .o_dprf_read_a2(o_dprf_read_a2),
      .i_dprf_d1(i_dprf_d1), .i_dprf_d2(i_dprf_d2), .i_fwd_reg(i_fwd_reg), .i_fwd_data(i_fwd_data),
      .i_fwd_pending(i_fwd_pending), .o_valid(o_valid), .o_pc(o_pc), .o_opcode(o_opcode),
      .o_dr(o_dr), .o_skp_mode(o_skp_mode), .o_sr1_val(o_sr1_val), .o_sr2_val(o_sr2_val),
      .o_target_address(o_target_address), .o_hazard(o_hazard), .o_hazard_cycles(o_hazard_cycles)
   );

   typedef struct packed {
      logic            v;
      logic [31:0]     pc;
      logic [3:0]      op;
      logic [RAW-1:0]  dr;
      logic            skp;
      logic [XLEN-1:0] s1, s2, tgt;
   } buf_t;

   typedef struct {
      logic           hz, stall, flush;
      logic [RAW-1:0] a1, a2;
      buf_t           b;
      logic [15:0]    cyc;
   } exp_t;

   localparam buf_t CLEARED = '{v: 1'b0, pc: '0, op: 4'hF, dr: '0, skp: 1'b0, s1: '0, s2: '0, tgt: '0};

   exp_t q[$];
   buf_t m_buf = CLEARED;
   int   m_cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: first matching bus in priority order wins, register 0 is hard zero.
   task automatic resolve(input logic [RAW-1:0] a, input logic [XLEN-1:0] rf,
                          output logic [XLEN-1:0] v, output bit p);
      v = rf;
      p = 1'b0;
      if (a == '0) begin
         v = '0;
         return;
      end
      for (int k = 0; k < NFWD; k++) begin
         if (i_fwd_reg[k*RAW +: RAW] == a) begin
            v = i_fwd_data[k*XLEN +: XLEN];
            p = i_fwd_pending[k];
            return;
         end
      end
   endtask

   // Called once per cycle after inputs settle; predicts this cycle's combinational outputs and the next buffer.
   task automatic issue();
      exp_t e;
      logic [XLEN-1:0] v1, v2;
      bit p1, p2, imm, hz;
      resolve(i_sr1, i_dprf_d1, v1, p1);
      resolve(i_sr2, i_dprf_d2, v2, p2);
      imm = ((MASK >> i_opcode) & 16'd1) != 16'd0;
      if (imm) v2 = i_imm32;
      hz = ILK && i_valid && (p1 || (!imm && p2));
      e.hz = hz;
      e.stall = i_pipe_stall || hz;
      e.flush = i_pipe_flush;
      e.a1 = i_sr1;
      e.a2 = i_sr2;
      if (i_reset || i_pipe_flush) m_buf = CLEARED;
      else if (i_pipe_stall) m_buf = m_buf;
      else if (hz) m_buf = CLEARED;
      else m_buf = '{v: i_valid, pc: i_pc, op: i_opcode, dr: i_dr, skp: i_skp_mode,
                     s1: v1, s2: v2, tgt: i_imm32};
      if (i_reset) m_cyc = 0;
      else if (hz && m_cyc < 65535) m_cyc++;
      e.b = m_buf;
      e.cyc = 16'(m_cyc);
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge i_clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("hazard", 64'(o_hazard), 64'(e.hz));
            check("pipe_stall", 64'(o_pipe_stall), 64'(e.stall));
            check("pipe_flush", 64'(o_pipe_flush), 64'(e.flush));
            check("read_a1", 64'(o_dprf_read_a1), 64'(e.a1));
            check("read_a2", 64'(o_dprf_read_a2), 64'(e.a2));
            check("valid", 64'(o_valid), 64'(e.b.v));
            check("pc", 64'(o_pc), 64'(e.b.pc));
            check("opcode", 64'(o_opcode), 64'(e.b.op));
            check("dr", 64'(o_dr), 64'(e.b.dr));
            check("skp_mode", 64'(o_skp_mode), 64'(e.b.skp));
            check("sr1_val", 64'(o_sr1_val), 64'(e.b.s1));
            check("sr2_val", 64'(o_sr2_val), 64'(e.b.s2));
            check("target", 64'(o_target_address), 64'(e.b.tgt));
            check("hazard_cycles", 64'(o_hazard_cycles), 64'(e.cyc));
         end
      end
   end

   task automatic idle();
      i_reset = 0; i_pipe_stall = 0; i_pipe_flush = 0; i_valid = 0; i_skp_mode = 0;
      i_pc = '0; i_opcode = 4'h0; i_dr = '0; i_sr1 = '0; i_sr2 = '0; i_imm32 = '0;
      i_dprf_d1 = '0; i_dprf_d2 = '0; i_fwd_reg = '0; i_fwd_data = '0; i_fwd_pending = '0;
   endtask

   task automatic set_fwd(input int k, input logic [RAW-1:0] r, input logic [XLEN-1:0] d, input bit p);
      i_fwd_reg[k*RAW +: RAW]    = r;
      i_fwd_data[k*XLEN +: XLEN] = d;
      i_fwd_pending[k]           = p;
   endtask

   task automatic cyc();
      issue();
      @(negedge i_clk);
   endtask

   initial begin : driver
      idle();
      @(negedge i_clk);
      i_reset = 1; cyc(); cyc();
      i_reset = 0; cyc();

      // forwarding priority
      i_valid = 1; i_pc = 32'h100; i_opcode = 4'h0; i_dr = 4'd9; i_sr1 = 4'd3;
      i_dprf_d1 = 32'hCCCC;
      set_fwd(0, 4'd3, 32'hAAAA, 0); set_fwd(1, 4'd3, 32'hBBBB, 0); cyc();
      set_fwd(0, 4'd5, 32'hAAAA, 0); cyc();
      i_sr1 = 4'd0; set_fwd(0, 4'd0, 32'hAAAA, 0); set_fwd(1, 4'd0, 32'hBBBB, 0); cyc();

      // immediate replaces a pending SR2
      i_opcode = 4'b0010; i_imm32 = 32'h1234; i_sr1 = 4'd1; i_sr2 = 4'd4;
      set_fwd(0, 4'd4, 32'hDEAD, 1); set_fwd(1, 4'd0, 32'h0, 0); cyc();

      // load-use: pending two cycles, then data lands
      i_reset = 1; cyc(); i_reset = 0;
      i_opcode = 4'h0; i_sr1 = 4'd0; i_sr2 = 4'd7; i_dprf_d2 = 32'h77;
      set_fwd(0, 4'd7, 32'h0, 1); cyc(); cyc();
      set_fwd(0, 4'd7, 32'h55, 0); cyc();

      // pending match on SR1 behind the interlock, then hold and flush under stall
      set_fwd(0, 4'd2, 32'h99, 1); i_sr1 = 4'd2; cyc();
      i_pipe_stall = 1;
      for (int i = 0; i < 3; i++) begin
         i_pc = $urandom; i_sr1 = 4'($urandom); i_dprf_d1 = $urandom; cyc();
      end
      i_pipe_flush = 1; cyc();
      idle(); cyc();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         i_reset      = ($urandom_range(0, 49) == 0);
         i_pipe_stall = ($urandom_range(0, 4) == 0);
         i_pipe_flush = ($urandom_range(0, 9) == 0);
         i_valid      = ($urandom_range(0, 3) != 0);
         i_pc         = $urandom;
         i_opcode     = ($urandom_range(0, 3) == 0) ? 4'b0010 : 4'($urandom);
         i_skp_mode   = 1'($urandom);
         i_dr         = 4'($urandom);
         i_sr1        = 4'($urandom_range(0, 7));
         i_sr2        = 4'($urandom_range(0, 7));
         i_imm32      = $urandom;
         i_dprf_d1    = $urandom;
         i_dprf_d2    = $urandom;
         for (int k = 0; k < NFWD; k++)
            set_fwd(k, 4'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 2) == 0));
         cyc();
      end
      idle(); cyc();

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge i_clk);
      #2;
      if (q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: got %0d pending expectations expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
